// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the barrel RISC-V core.
// Keeps one PC per hart and fetches from the harts in round-robin order, one per
// non-stalled cycle. Each fetch issues a synchronous BRAM read. The returned word
// reaches the decoder one cycle later, together with its PC and hart ID.
// A redirect from execute overwrites a hart's PC. If that hart is being fetched
// in the same cycle, the in-flight fetch is squashed.
// Optional build macro IFU_PERF_COUNTER_EN adds o_fetch_count, which counts
// non-squashed fetches.
module instruction_fetch_unit #(
  parameter int          NUM_THREADS     = 16,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic                           i_redirect_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] i_redirect_tid,
  input  logic [31:0]                    i_redirect_pc,
  output logic                           o_imem_en,
  output logic [IMEM_ADDR_WIDTH-1:0]     o_imem_addr,
  input  logic [31:0]                    i_imem_rdata,
  output logic [31:0]                    o_instruction,
  output logic [31:0]                    o_pc,
  output logic [$clog2(NUM_THREADS)-1:0] o_tid,
  output logic                           o_valid
`ifdef IFU_PERF_COUNTER_EN
  ,
  output logic [31:0]                    o_fetch_count
`endif
);

  localparam int TID_W = $clog2(NUM_THREADS);

  logic [31:0]      r_pc [NUM_THREADS];
  logic [TID_W-1:0] r_tid_f;

  logic [31:0]      r_pc_p1;
  logic [TID_W-1:0] r_tid_p1;
  logic             r_vld_p1;

  logic             w_fetch;
  logic             w_squash;
  logic [31:0]      w_fetch_pc;
  logic [31:0]      w_redirect_pc;

  assign w_fetch       = !i_rst && !i_stall;
  assign w_fetch_pc    = r_pc[r_tid_f];
  // Word-align the redirect target; the low two bits are dropped.
  assign w_redirect_pc = i_redirect_pc & ~32'd3;
  // A redirect to the hart being fetched makes the in-flight fetch stale.
  assign w_squash      = i_redirect_valid && (i_redirect_tid == r_tid_f);

  assign o_imem_en     = w_fetch;
  assign o_imem_addr   = w_fetch_pc[IMEM_ADDR_WIDTH+1:2];
  assign o_instruction = i_imem_rdata;
  assign o_pc          = r_pc_p1;
  assign o_tid         = r_tid_p1;
  assign o_valid       = r_vld_p1;

  // Per-hart PC file: a redirect has priority over the sequential +4 advance.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (i_rst) begin
        r_pc[i] <= RESET_PC;
      end else if (i_redirect_valid && (i_redirect_tid == TID_W'(i))) begin
        r_pc[i] <= w_redirect_pc;
      end else if (w_fetch && (r_tid_f == TID_W'(i))) begin
        r_pc[i] <= r_pc[i] + 32'd4;
      end
    end
  end

  // Round-robin fetch pointer; wraps naturally because NUM_THREADS is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tid_f <= '0;
    end else if (w_fetch) begin
      r_tid_f <= r_tid_f + TID_W'(1);
    end
  end

  // ---- fetch -> decode boundary: PC/hart/valid aligned with the BRAM read data ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_p1  <= '0;
      r_tid_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_fetch) begin
      r_pc_p1  <= w_fetch_pc;
      r_tid_p1 <= r_tid_f;
      r_vld_p1 <= !w_squash;
    end
  end

`ifdef IFU_PERF_COUNTER_EN
  logic [31:0] r_fetch_count;

  // Count fetches that reach the decoder as valid; wraps at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_count <= '0;
    end else if (w_fetch && !w_squash) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (NUM_THREADS=4).
// A behavioural BRAM and a per-hart PC reference model predict every output.
module tb_instruction_fetch_unit;

  localparam int          NT  = 4;
  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk;
  logic          i_rst, i_stall, i_redirect_valid;
  logic [1:0]    i_redirect_tid;
  logic [31:0]   i_redirect_pc;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   o_instruction, o_pc;
  logic [1:0]    o_tid;
  logic          o_valid;
`ifdef IFU_PERF_COUNTER_EN
  logic [31:0]   o_fetch_count;
`endif

  instruction_fetch_unit #(.NUM_THREADS(NT), .RESET_PC(RPC), .IMEM_ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall),
    .i_redirect_valid(i_redirect_valid), .i_redirect_tid(i_redirect_tid),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_en(imem_en), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_tid(o_tid), .o_valid(o_valid)
`ifdef IFU_PERF_COUNTER_EN
    , .o_fetch_count(o_fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction BRAM: synchronous read, output held while disabled.
  logic [31:0] mem [1 << AW];
  initial imem_rdata = 32'h0;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  // Reference model
  logic [31:0]   m_pc [NT];
  int            m_tid;
  logic [31:0]   m_opc, m_oinst, m_cnt;
  int            m_otid;
  bit            m_ovld;
  bit            exp_en, obs_en;
  logic [AW-1:0] exp_addr, obs_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Drive one cycle, capture pre-edge fetch signals, advance the model at the edge.
  task automatic cycle(input bit rst, input bit stall, input bit rv,
                       input int rtid, input logic [31:0] rpc);
    logic [31:0] fpc;
    i_rst = rst; i_stall = stall; i_redirect_valid = rv;
    i_redirect_tid = rtid[1:0]; i_redirect_pc = rpc;
    #2;
    obs_en = imem_en; obs_addr = imem_addr;
    exp_en = !rst && !stall;
    fpc = m_pc[m_tid];
    exp_addr = fpc[AW+1:2];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NT; i++) m_pc[i] = RPC;
      m_tid = 0; m_ovld = 0; m_opc = 0; m_otid = 0; m_cnt = 0;
    end else begin
      if (!stall) begin
        m_opc   = fpc;
        m_otid  = m_tid;
        m_ovld  = !(rv && rtid == m_tid);
        m_oinst = mem[fpc[AW+1:2]];
        if (m_ovld) m_cnt = m_cnt + 1;
        m_pc[m_tid] = fpc + 32'd4;
        m_tid = (m_tid + 1) % NT;
      end
      if (rv) m_pc[rtid] = {rpc[31:2], 2'b00};
    end
    #1;
  endtask

  task automatic goto_tid(input int t);
    for (int k = 0; k < NT && m_tid != t; k++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 2, 32'h55);
    n_checks++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL rst_en got %0b want 0", obs_en); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", o_valid); end
    n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", o_pc); end
    n_checks++; if (o_tid !== 2'd0) begin n_fail++; $display("FAIL rst_tid got %0d want 0", o_tid); end
`ifdef IFU_PERF_COUNTER_EN
    n_checks++; if (o_fetch_count !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", o_fetch_count); end
`endif
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic test_sequence;
    int exp_a [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_checks++; if (obs_en !== 1'b1) begin n_fail++; $display("FAIL seq_en[%0d] got %0b want 1", i, obs_en); end
      n_checks++; if (obs_addr !== AW'(exp_a[i])) begin n_fail++; $display("FAIL seq_addr[%0d] got %0d want %0d", i, obs_addr, exp_a[i]); end
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %0b want 1", i, o_valid); end
      n_checks++; if (o_tid !== 2'(i % 4)) begin n_fail++; $display("FAIL seq_tid[%0d] got %0d want %0d", i, o_tid, i % 4); end
      n_checks++; if (o_pc !== ((i < 4) ? 32'd0 : 32'd4)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, o_pc, (i < 4) ? 0 : 4); end
      n_checks++; if (o_instruction !== m_oinst) begin n_fail++; $display("FAIL seq_inst[%0d] got %h want %h", i, o_instruction, m_oinst); end
    end
  endtask

  task automatic test_redirect_other;
    goto_tid(0);
    cycle(0, 0, 1, 2, 32'h0000_0103);
    n_checks++; if (o_valid !== 1'b1 || o_tid !== 2'd0) begin n_fail++; $display("FAIL rdo_nosquash got v=%0b t=%0d want v=1 t=0", o_valid, o_tid); end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (obs_addr !== AW'(10'h40)) begin n_fail++; $display("FAIL rdo_addr got %h want 40", obs_addr); end
    n_checks++; if (o_pc !== 32'h100 || o_tid !== 2'd2 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rdo_out got pc=%h t=%0d v=%0b want pc=100 t=2 v=1", o_pc, o_tid, o_valid); end
  endtask

  task automatic test_redirect_same;
    goto_tid(1);
    cycle(0, 0, 1, 1, 32'h200);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rds_squash got v=%0b want 0", o_valid); end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0);
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rds_resume got v=%0b want 1", o_valid); end
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (o_pc !== 32'h200 || o_tid !== 2'd1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rds_out got pc=%h t=%0d v=%0b want pc=200 t=1 v=1", o_pc, o_tid, o_valid); end
  endtask

  task automatic test_stall;
    logic [31:0] s_pc, s_inst;
    logic [1:0]  s_tid;
    logic        s_vld;
    int          s_next;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    s_pc = o_pc; s_tid = o_tid; s_vld = o_valid; s_inst = o_instruction; s_next = m_tid;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0);
      n_checks++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d] got %0b want 0", k, obs_en); end
      n_checks++; if (o_pc !== s_pc || o_tid !== s_tid || o_valid !== s_vld || o_instruction !== s_inst) begin
        n_fail++; $display("FAIL stall_hold[%0d] got pc=%h t=%0d v=%0b i=%h want pc=%h t=%0d v=%0b i=%h",
                           k, o_pc, o_tid, o_valid, o_instruction, s_pc, s_tid, s_vld, s_inst);
      end
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (o_tid !== 2'(s_next) || o_valid !== 1'b1 || o_pc !== m_opc) begin n_fail++; $display("FAIL stall_resume got t=%0d pc=%h want t=%0d pc=%h", o_tid, o_pc, s_next, m_opc); end
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (o_tid !== 2'((s_next + 1) % NT)) begin n_fail++; $display("FAIL stall_next got t=%0d want %0d", o_tid, (s_next + 1) % NT); end
  endtask

  task automatic test_wrap;
    goto_tid(1);
    cycle(0, 0, 1, 0, 32'hFFFF_FFFC);
    goto_tid(0);
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (obs_addr !== AW'(10'h3FF)) begin n_fail++; $display("FAIL wrap_addr got %h want 3ff", obs_addr); end
    n_checks++; if (o_pc !== 32'hFFFF_FFFC || o_tid !== 2'd0) begin n_fail++; $display("FAIL wrap_top got pc=%h t=%0d want pc=fffffffc t=0", o_pc, o_tid); end
    for (int k = 0; k < NT; k++) cycle(0, 0, 0, 0, 0);
    n_checks++; if (o_pc !== 32'h0 || o_tid !== 2'd0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got pc=%h t=%0d v=%0b want pc=0 t=0 v=1", o_pc, o_tid, o_valid); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      bit rst, st, rv;
      int rt;
      logic [31:0] rp;
      rst = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 2) == 0);
      rt  = $urandom_range(0, NT - 1);
      rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(rst, st, rv, rt, rp);
      n_checks++; if (obs_en !== exp_en) begin n_fail++; $display("FAIL rnd_en[%0d] got %0b want %0b", n, obs_en, exp_en); end
      if (exp_en) begin
        n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", n, obs_addr, exp_addr); end
      end
      n_checks++; if (o_valid !== m_ovld) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, o_valid, m_ovld); end
      if (m_ovld) begin
        n_checks++; if (o_pc !== m_opc || o_tid !== 2'(m_otid) || o_instruction !== m_oinst) begin
          n_fail++; $display("FAIL rnd_out[%0d] got pc=%h t=%0d i=%h want pc=%h t=%0d i=%h",
                             n, o_pc, o_tid, o_instruction, m_opc, m_otid, m_oinst);
        end
      end
`ifdef IFU_PERF_COUNTER_EN
      n_checks++; if (o_fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, o_fetch_count, m_cnt); end
`endif
    end
  endtask

  task automatic test_reset_midstream;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 32'h40);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got %0b want 0", o_valid); end
`ifdef IFU_PERF_COUNTER_EN
    n_checks++; if (o_fetch_count !== 32'd0) begin n_fail++; $display("FAIL mrst_cnt got %0d want 0", o_fetch_count); end
`endif
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0, 0);
      n_checks++; if (o_valid !== 1'b1 || o_tid !== 2'(k) || o_pc !== RPC) begin
        n_fail++; $display("FAIL mrst_fetch[%0d] got v=%0b t=%0d pc=%h want v=1 t=%0d pc=%h", k, o_valid, o_tid, o_pc, k, RPC);
      end
`ifdef IFU_PERF_COUNTER_EN
      n_checks++; if (o_fetch_count !== 32'(k + 1)) begin n_fail++; $display("FAIL mrst_count[%0d] got %0d want %0d", k, o_fetch_count, k + 1); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int i = 0; i < NT; i++) m_pc[i] = 32'h0;
    m_tid = 0; m_opc = 0; m_otid = 0; m_ovld = 0; m_oinst = 0; m_cnt = 0;
    i_rst = 1; i_stall = 0; i_redirect_valid = 0; i_redirect_tid = 0; i_redirect_pc = 0;
    test_reset;
    test_sequence;
    test_redirect_other;
    test_redirect_same;
    test_stall;
    test_wrap;
    test_random;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
